// File: rtl/bids22_cmd_sequencer.sv
// Host command FIFO feeding the bids22 controller one command at a time (C_op valid one cycle, >=2 cycles/command).
// Backpressure: cmd_ready drops when the FIFO is full; dispatch stalls on pause or controller not ready.
module bids22_cmd_sequencer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_op,
  input  logic [31:0]              cmd_data,
  input  logic                     pause,
  input  logic                     clr_stats,
  output logic [3:0]               C_op,
  output logic [31:0]              C_data,
  output logic                     C_start,
  input  logic                     dut_ready,
  input  logic                     dut_err,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         issued_cnt,
  output logic [CNT_W-1:0]         err_cnt,
  output logic                     timeout_flag
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_START = 4'hF;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] data;
  } cmd_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  cmd_t              mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  state_t            state_q, state_d;
  logic              issue_q, issue_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              err_seen_q, err_seen_d;
  logic [3:0]        c_op_q, c_op_d;
  logic [31:0]       c_data_q, c_data_d;
  logic              c_start_q, c_start_d;
  logic [CNT_W-1:0]  issued_q, issued_d, err_q, err_d;
  logic              to_q, to_d;

  logic              push, pop, empty;
  logic              inc_iss, inc_err, set_to;
  cmd_t              head;

  assign empty     = (count_q == '0);
  assign cmd_ready = (count_q < CW'(DEPTH));
  assign push      = cmd_valid & cmd_ready;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    issue_d    = 1'b0;
    timer_d    = timer_q;
    err_seen_d = err_seen_q;
    c_op_d     = 4'h0;
    c_data_d   = 32'h0;
    c_start_d  = c_start_q;
    pop        = 1'b0;
    inc_iss    = 1'b0;
    inc_err    = 1'b0;
    set_to     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && !pause) begin
          if (head.op == OP_NOP) begin
            pop     = 1'b1;
            inc_iss = 1'b1;
          end else if (head.op == OP_START) begin
            pop       = 1'b1;
            c_start_d = head.data[0];
            inc_iss   = 1'b1;
          end else if (dut_ready) begin
            pop        = 1'b1;
            c_op_d     = head.op;
            c_data_d   = head.data;
            state_d    = S_WAIT;
            issue_d    = 1'b1;
            timer_d    = '0;
            err_seen_d = 1'b0;
          end
        end
      end
      S_WAIT: begin
        // The issue cycle itself (C_op valid) never samples ready/err.
        if (!issue_q) begin
          if (dut_ready) begin
            inc_iss    = 1'b1;
            inc_err    = err_seen_q | dut_err;
            state_d    = S_IDLE;
            err_seen_d = 1'b0;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            set_to     = 1'b1;
            inc_iss    = 1'b1;
            inc_err    = 1'b1;
            state_d    = S_IDLE;
            err_seen_d = 1'b0;
          end else begin
            timer_d    = timer_q + 1'b1;
            err_seen_d = err_seen_q | dut_err;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;

    issued_d = issued_q;
    err_d    = err_q;
    to_d     = to_q | set_to;
    if (inc_iss && issued_q != '1) issued_d = issued_q + 1'b1;
    if (inc_err && err_q != '1)    err_d    = err_q + 1'b1;
    if (clr_stats) begin
      issued_d = '0;
      err_d    = '0;
      to_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{op: cmd_op, data: cmd_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      issue_q    <= 1'b0;
      timer_q    <= '0;
      err_seen_q <= 1'b0;
      c_op_q     <= 4'h0;
      c_data_q   <= 32'h0;
      c_start_q  <= 1'b0;
      issued_q   <= '0;
      err_q      <= '0;
      to_q       <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      issue_q    <= issue_d;
      timer_q    <= timer_d;
      err_seen_q <= err_seen_d;
      c_op_q     <= c_op_d;
      c_data_q   <= c_data_d;
      c_start_q  <= c_start_d;
      issued_q   <= issued_d;
      err_q      <= err_d;
      to_q       <= to_d;
    end
  end

  assign C_op         = c_op_q;
  assign C_data       = c_data_q;
  assign C_start      = c_start_q;
  assign busy         = !empty || (state_q != S_IDLE);
  assign fifo_count   = count_q;
  assign issued_cnt   = issued_q;
  assign err_cnt      = err_q;
  assign timeout_flag = to_q;

endmodule
